// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths for the SBox sharing logic.
package aes_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ST_SUB,
        KEY_SUB,
        ST_DONE,
        KEY_DONE
    } sbox_arb_state_t;

endpackage

// File: rtl/word_shift_reg.sv
// 128-bit register with parallel load and a left shift by one 32-bit word.
module word_shift_reg
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               shift,
    input  logic [WORD_W-1:0]  shift_in,
    output logic [BLOCK_W-1:0] q
);

    // Load wins over shift; the new word enters at the bottom.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[BLOCK_W-WORD_W-1:0], shift_in};
        end
    end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin, non-preemptive sharing of a 4-lane SBox word path between the
// round datapath (SubBytes) and key expansion (SubWord). Optional counters: SBOX_SHARE_STATS_EN.
module sbox_share_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned HDR_W       = 4,
    parameter int unsigned BEATS       = 4,
    parameter bit          RR_INIT_KEY = 1'b1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     st_req_valid,
    output logic                     st_req_ready,
    input  logic [HDR_W+BLOCK_W-1:0] st_data_in,
    output logic                     st_resp_valid,
    input  logic                     st_resp_ready,
    output logic [HDR_W+BLOCK_W-1:0] st_data_out,
    input  logic                     key_req_valid,
    output logic                     key_req_ready,
    input  logic [WORD_W-1:0]        key_word_in,
    output logic                     key_resp_valid,
    input  logic                     key_resp_ready,
    output logic [WORD_W-1:0]        key_word_out,
    output logic [WORD_W-1:0]        sbox_in,
    input  logic [WORD_W-1:0]        sbox_out,
    output logic                     busy
`ifdef SBOX_SHARE_STATS_EN
    ,
    output logic [STAT_W-1:0]        key_wait_cycles,
    output logic [STAT_W-1:0]        st_blocks_done
`endif
);

    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PAD_W  = BLOCK_W - WORD_W;

    sbox_arb_state_t    state_q, state_d;
    logic [BEAT_W-1:0]  beat_q;
    logic               rr_key_q;
    logic [HDR_W-1:0]   hdr_q;
    logic [BLOCK_W-1:0] op_q, res_q, op_load_data;
    logic               st_elig, key_elig;
    logic               st_grant, key_grant, sub_shift, key_cap, st_done, key_done;

    assign st_elig  = st_req_valid && !st_resp_valid;
    assign key_elig = key_req_valid && !key_resp_valid;

    assign st_req_ready  = st_grant;
    assign key_req_ready = key_grant;

    // Key words ride in the top lane; the zero fill leaves the operand empty once consumed.
    assign op_load_data = st_grant ? st_data_in[BLOCK_W-1:0] : {key_word_in, {PAD_W{1'b0}}};
    assign sbox_in      = op_q[BLOCK_W-1 -: WORD_W];
    assign st_data_out  = {hdr_q, res_q};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_grant  = 1'b0;
        key_grant = 1'b0;
        sub_shift = 1'b0;
        key_cap   = 1'b0;
        st_done   = 1'b0;
        key_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (st_elig && (!key_elig || !rr_key_q)) begin
                    st_grant = 1'b1;
                    state_d  = ST_SUB;
                end else if (key_elig) begin
                    key_grant = 1'b1;
                    state_d   = KEY_SUB;
                end
            end
            ST_SUB: begin
                sub_shift = 1'b1;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            KEY_SUB: begin
                key_cap = 1'b1;
                state_d = KEY_DONE;
            end
            ST_DONE: begin
                st_done = 1'b1;
                state_d = IDLE;
            end
            KEY_DONE: begin
                key_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_q         <= '0;
            rr_key_q       <= RR_INIT_KEY;
            hdr_q          <= '0;
            key_word_out   <= '0;
            st_resp_valid  <= 1'b0;
            key_resp_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (st_grant) begin
                beat_q <= '0;
            end else if (sub_shift) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
            // Pointer always favours the side that was not just served.
            if (st_grant) begin
                rr_key_q <= 1'b1;
            end else if (key_grant) begin
                rr_key_q <= 1'b0;
            end
            if (st_grant) begin
                hdr_q <= st_data_in[BLOCK_W +: HDR_W];
            end
            if (key_cap) begin
                key_word_out <= sbox_out;
            end
            if (st_done) begin
                st_resp_valid <= 1'b1;
            end else if (st_resp_ready) begin
                st_resp_valid <= 1'b0;
            end
            if (key_done) begin
                key_resp_valid <= 1'b1;
            end else if (key_resp_ready) begin
                key_resp_valid <= 1'b0;
            end
        end
    end

    word_shift_reg u_operand (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (st_grant || key_grant),
        .load_data(op_load_data),
        .shift    (sub_shift || key_cap),
        .shift_in ({WORD_W{1'b0}}),
        .q        (op_q)
    );

    word_shift_reg u_result (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (1'b0),
        .load_data({BLOCK_W{1'b0}}),
        .shift    (sub_shift),
        .shift_in (sbox_out),
        .q        (res_q)
    );

`ifdef SBOX_SHARE_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_wait_cycles <= '0;
            st_blocks_done  <= '0;
        end else begin
            if (key_req_valid && !key_req_ready && (key_wait_cycles != {STAT_W{1'b1}})) begin
                key_wait_cycles <= key_wait_cycles + STAT_W'(1);
            end
            if (st_done && (st_blocks_done != {STAT_W{1'b1}})) begin
                st_blocks_done <= st_blocks_done + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Scoreboard bench for sbox_share_arbiter with a behavioural AES SBox bank.
module tb_sbox_share_arbiter;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [131:0] V_A = {4'hA, 128'h00112233445566778899aabbccddeeff};
    localparam logic [131:0] E_A = {4'hA, 128'h638293c31bfc33f5c4eeacea4bc12816};
    localparam logic [131:0] V_1 = {4'h5, 128'h0};
    localparam logic [131:0] E_1 = {4'h5, 128'h63636363636363636363636363636363};
    localparam logic [131:0] V_2 = {4'h3, 128'hffeeddccbbaa99887766554433221100};
    localparam logic [131:0] E_2 = {4'h3, 128'h1628c14beaaceec4f533fc1bc3938263};
    localparam logic [131:0] V_4 = {4'hF, 128'h09cf4f3c00112233ffffffff00000000};
    localparam logic [131:0] E_4 = {4'hF, 128'h018a84eb638293c31616161663636363};

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         st_req_valid, st_req_ready, st_resp_valid, st_resp_ready;
    logic [131:0] st_data_in, st_data_out;
    logic         key_req_valid, key_req_ready, key_resp_valid, key_resp_ready;
    logic [31:0]  key_word_in, key_word_out, sbox_in, sbox_out;
    logic         busy;
`ifdef SBOX_SHARE_STATS_EN
    logic [15:0]  key_wait_cycles, st_blocks_done;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [131:0] st_exp[$];
    int           st_lat[$];
    logic [31:0]  key_exp[$];
    int           key_lat[$];
    bit           grant_log[$];

    sbox_share_arbiter dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .st_req_valid  (st_req_valid),
        .st_req_ready  (st_req_ready),
        .st_data_in    (st_data_in),
        .st_resp_valid (st_resp_valid),
        .st_resp_ready (st_resp_ready),
        .st_data_out   (st_data_out),
        .key_req_valid (key_req_valid),
        .key_req_ready (key_req_ready),
        .key_word_in   (key_word_in),
        .key_resp_valid(key_resp_valid),
        .key_resp_ready(key_resp_ready),
        .key_word_out  (key_word_out),
        .sbox_in       (sbox_in),
        .sbox_out      (sbox_out),
        .busy          (busy)
`ifdef SBOX_SHARE_STATS_EN
        ,
        .key_wait_cycles(key_wait_cycles),
        .st_blocks_done (st_blocks_done)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX_TBL[(255 - int'(w[8*i +: 8]))*8 +: 8];
        end
        return r;
    endfunction

    assign sbox_out = sub_word(sbox_in);

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    task automatic st_send(input logic [131:0] d, input logic [131:0] e);
        int n = 0;
        st_data_in   = d;
        st_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!st_req_ready && n < 300);
        if (!st_req_ready) begin
            fail_now("st_accept");
        end else begin
            st_exp.push_back(e);
            st_lat.push_back(cyc + 6);
            grant_log.push_back(1'b0);
        end
        @(posedge clk);
        #1 st_req_valid = 1'b0;
    endtask

    task automatic key_send(input logic [31:0] w, input logic [31:0] e, output int stalls);
        int n = 0;
        key_word_in   = w;
        key_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!key_req_ready && n < 300);
        stalls = n - 1;
        if (!key_req_ready) begin
            fail_now("key_accept");
        end else begin
            key_exp.push_back(e);
            key_lat.push_back(cyc + 3);
            grant_log.push_back(1'b1);
        end
        @(posedge clk);
        #1 key_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((st_exp.size() != 0 || key_exp.size() != 0 || busy || st_resp_valid || key_resp_valid)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 n_rst = 1'b0;
        st_exp.delete();
        st_lat.delete();
        key_exp.delete();
        key_lat.delete();
        #1;
        check("reset_outputs", {st_req_ready, st_resp_valid, st_data_out, key_req_ready,
              key_resp_valid, key_word_out, sbox_in, busy}, 256'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: latency, data, and hold-while-stalled checks.
    logic         st_v_prev = 1'b0, key_v_prev = 1'b0, st_pend = 1'b0, key_pend = 1'b0;
    logic [131:0] st_hold;
    logic [31:0]  key_hold;
    always @(negedge clk) begin
        if (!n_rst) begin
            st_v_prev = 1'b0; key_v_prev = 1'b0; st_pend = 1'b0; key_pend = 1'b0;
        end else begin
            if (st_resp_valid && !st_v_prev) begin
                if (st_lat.size() == 0) fail_now("st_resp_unexpected");
                else check("st_latency", 256'(cyc), 256'(st_lat.pop_front()));
            end
            if (st_pend) check("st_hold", {st_resp_valid, st_data_out}, {1'b1, st_hold});
            if (st_resp_valid && st_resp_ready) begin
                if (st_exp.size() == 0) fail_now("st_data_unexpected");
                else check("st_data", st_data_out, st_exp.pop_front());
            end
            st_pend   = st_resp_valid && !st_resp_ready;
            st_hold   = st_data_out;
            st_v_prev = st_resp_valid;

            if (key_resp_valid && !key_v_prev) begin
                if (key_lat.size() == 0) fail_now("key_resp_unexpected");
                else check("key_latency", 256'(cyc), 256'(key_lat.pop_front()));
            end
            if (key_pend) check("key_hold", {key_resp_valid, key_word_out}, {1'b1, key_hold});
            if (key_resp_valid && key_resp_ready) begin
                if (key_exp.size() == 0) fail_now("key_data_unexpected");
                else check("key_data", key_word_out, key_exp.pop_front());
            end
            key_pend   = key_resp_valid && !key_resp_ready;
            key_hold   = key_word_out;
            key_v_prev = key_resp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int n;
        bit exp_order[8];
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        st_req_valid = 1'b0; st_data_in = '0; st_resp_ready = 1'b1;
        key_req_valid = 1'b0; key_word_in = '0; key_resp_ready = 1'b1;

        #2 n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {st_req_ready, st_resp_valid, st_data_out, key_req_ready,
              key_resp_valid, key_word_out, sbox_in, busy}, 256'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // State only, then key only.
        st_send(V_A, E_A);
        check("busy_after_accept", 256'(busy), 256'd1);
        wait_drain();
        key_send(32'h09cf4f3c, 32'h018a84eb, stalls);
        wait_drain();

        // Contested: both sides keep requesting from reset.
        do_reset();
        grant_log.delete();
        fork
            begin
                st_send(V_1, E_1); st_send(V_2, E_2); st_send(V_A, E_A); st_send(V_4, E_4);
            end
            begin
                int s;
                key_send(32'h00112233, 32'h638293c3, s);
                key_send(32'hffeeddcc, 32'h1628c14b, s);
                key_send(32'h44556677, 32'h1bfc33f5, s);
                key_send(32'h8899aabb, 32'hc4eeacea, s);
            end
        join
        wait_drain();
        check("grant_count", 256'(grant_log.size()), 256'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check($sformatf("grant_order_%0d", i), 256'(grant_log[i]), 256'(exp_order[i]));
        end

        // Key request arriving during state beat 1.
        do_reset();
        st_send(V_2, E_2);
        @(posedge clk);
        #1;
        key_send(32'h09cf4f3c, 32'h018a84eb, stalls);
        check("key_stall_cycles", 256'(stalls), 256'd4);
        wait_drain();
`ifdef SBOX_SHARE_STATS_EN
        check("key_wait_cycles", 256'(key_wait_cycles), 256'd4);
`endif

        // State response stalled by its consumer.
        st_resp_ready = 1'b0;
        st_send(V_1, E_1);
        n = 0;
        while (!st_resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!st_resp_valid) fail_now("st_resp_wait");
        @(posedge clk);
        #1;
        st_data_in   = V_4;
        st_req_valid = 1'b1;
        n = 0;
        fork
            key_send(32'h8899aabb, 32'hc4eeacea, stalls);
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (st_req_ready) n++;
                end
            end
        join
        check("st_blocked_ready_cycles", 256'(n), 256'd0);
        @(posedge clk);
        #1 st_resp_ready = 1'b1;
        st_send(V_4, E_4);
        wait_drain();

        // Reset during state beat 2.
        st_send(V_A, E_A);
        @(posedge clk);
        #1;
        check("busy_before_reset", 256'(busy), 256'd1);
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        st_send(V_2, E_2);
        wait_drain();
        key_send(32'hffeeddcc, 32'h1628c14b, stalls);
        wait_drain();
`ifdef SBOX_SHARE_STATS_EN
        check("st_blocks_done", 256'(st_blocks_done), 256'd1);
        check("key_wait_after_reset", 256'(key_wait_cycles), 256'd0);
`endif

        check("leftover_expectations", 256'(st_exp.size() + key_exp.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
